// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control logic.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
// Contents: register-zero constant, hazard FSM state encoding, pipeline field widths,
//           and a register-match helper used by the hazard detector.
package mips_pkg;

  localparam int REG_W = 5;
  localparam int WB_W  = 2;
  localparam int M_W   = 2;
  localparam int EX_W  = 4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  // True when a producer's destination feeds either ID operand. $zero is never a
  // real dependency because writes to it are discarded.
  function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt);
    return (dst != REG_ZERO) && ((dst == rs) || (dst == rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and asynchronous clear.
// Latency: count updates on the clock edge that samples inc_i=1.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk_i, rst_i (async active-high clear), inc_i (count enable), cnt_o (W-bit count).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard/flush controller for a 5-stage MIPS pipeline with branches resolved in ID.
// Latency: control outputs are combinational in the same cycle; counters and err_o update on the edge.
// Backpressure: stall freezes PC and IF/ID and bubbles ID/EX; stall overrides any flush.
// Ports: IF/ID operand fields, ID branch/jump info, ID/EX and EX/MEM destination info in;
//        PC/IF-ID write enables, IF/ID flush, ID/EX bubble, perf counters, sticky err_o out.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             id_branch_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             idex_regwrite_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_dst_i,
  input  logic             exmem_memread_i,
  input  logic [4:0]       exmem_rd_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o
);

  // Run counter is at least 3 bits and wide enough to hold MAX_STALL.
  localparam int RUN_W = ($clog2(MAX_STALL + 1) > 3) ? $clog2(MAX_STALL + 1) : 3;
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

  logic m_ex;
  logic m_mem;
  logic stall;
  logic flush;

  hz_state_e        state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;

  // Hazard detection and control outputs.
  always_comb begin
    m_ex  = reg_match(idex_dst_i, ifid_rs_i, ifid_rt_i);
    m_mem = reg_match(exmem_rd_i, ifid_rs_i, ifid_rt_i);

    // Load-use always stalls; a branch compares in ID so it also waits for an
    // ALU result still in EX and for a load result still in MEM.
    stall = (idex_memread_i & m_ex)
          | (id_branch_i & idex_regwrite_i & m_ex)
          | (id_branch_i & exmem_memread_i & m_mem);

    // A redirect is only acted on once its operands are available.
    flush = ~stall & (jump_i | (id_branch_i & branch_taken_i));

    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else begin
      pc_write_o    = ~stall;
      ifid_write_o  = ~stall;
      ifid_flush_o  = flush;
      idex_bubble_o = stall;
    end
  end

  // Cycle classification and watchdog next-state.
  always_comb begin
    if (stall) begin
      state_d = ST_STALL;
    end else if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      state_d = ST_RUN;
    end

    run_d = '0;
    if (state_d == ST_STALL) begin
      if (state_q != ST_STALL) begin
        run_d = {{(RUN_W-1){1'b0}}, 1'b1};
      end else if (&run_q) begin
        run_d = run_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end

    err_d = err_q | (run_d >= RUN_LIMIT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (state_d == ST_STALL),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (state_d == ST_FLUSH),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the hazard rules.
// Counters use a narrow width so saturation is reached during the random phase.
module tb_hazard_unit;

  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       ifid_rs, ifid_rt, idex_dst, exmem_rd;
  logic             id_branch, branch_taken, jump;
  logic             idex_regwrite, idex_memread, exmem_memread;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state.
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;
  int m_run       = 0;
  bit m_err       = 1'b0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ifid_rs_i       (ifid_rs),
    .ifid_rt_i       (ifid_rt),
    .id_branch_i     (id_branch),
    .branch_taken_i  (branch_taken),
    .jump_i          (jump),
    .idex_regwrite_i (idex_regwrite),
    .idex_memread_i  (idex_memread),
    .idex_dst_i      (idex_dst),
    .exmem_memread_i (exmem_memread),
    .exmem_rd_i      (exmem_rd),
    .pc_write_o      (pc_write),
    .ifid_write_o    (ifid_write),
    .ifid_flush_o    (ifid_flush),
    .idex_bubble_o   (idex_bubble),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt),
    .err_o           (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Does the instruction in ID depend on a producer writing register dst?
  function automatic bit uses(input logic [4:0] dst);
    return (dst != 0) && (dst == ifid_rs || dst == ifid_rt);
  endfunction

  function automatic bit model_stall();
    bit load_use, br_alu, br_load;
    load_use = idex_memread && uses(idex_dst);
    br_alu   = id_branch && idex_regwrite && uses(idex_dst);
    br_load  = id_branch && exmem_memread && uses(exmem_rd);
    return load_use || br_alu || br_load;
  endfunction

  function automatic bit model_flush();
    return !model_stall() && (jump || (id_branch && branch_taken));
  endfunction

  // Model bookkeeping: what each clock edge does to counters and watchdog.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      m_run       = 0;
      m_err       = 1'b0;
    end else begin
      if (model_stall()) begin
        if (m_stall_cnt < CNT_MAX) m_stall_cnt = m_stall_cnt + 1;
        m_run = m_run + 1;
      end else begin
        m_run = 0;
      end
      if (model_flush() && m_flush_cnt < CNT_MAX) m_flush_cnt = m_flush_cnt + 1;
      if (m_run >= MAX_STALL) m_err = 1'b1;
    end
  end

  // Compare process: mid-cycle, inputs stable, outputs settled.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        chk("pc_write", pc_write, 0);
        chk("ifid_write", ifid_write, 0);
        chk("ifid_flush", ifid_flush, 0);
        chk("idex_bubble", idex_bubble, 1);
      end else begin
        chk("pc_write", pc_write, !model_stall());
        chk("ifid_write", ifid_write, !model_stall());
        chk("ifid_flush", ifid_flush, model_flush());
        chk("idex_bubble", idex_bubble, model_stall());
      end
      chk("stall_cnt", stall_cnt, m_stall_cnt);
      chk("flush_cnt", flush_cnt, m_flush_cnt);
      chk("err", err, m_err);
    end
  end

  task automatic idle();
    ifid_rs = 0; ifid_rt = 0; idex_dst = 0; exmem_rd = 0;
    id_branch = 0; branch_taken = 0; jump = 0;
    idex_regwrite = 0; idex_memread = 0; exmem_memread = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_8();
    idex_memread = 1; idex_dst = 8; ifid_rs = 8;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #2;
    // Reset state
    chk("rst pc_write", pc_write, 0);
    chk("rst ifid_write", ifid_write, 0);
    chk("rst bubble", idex_bubble, 1);
    chk("rst flush", ifid_flush, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst flush_cnt", flush_cnt, 0);
    chk("rst err", err, 0);
    tick();
    rst = 0;
    chk_en = 1;
    #1 chk("post-rst pc_write", pc_write, 1);

    // Load-use: one stall cycle
    tick(); idle(); load_use_8();
    #1 chk("lu pc_write", pc_write, 0);
    chk("lu ifid_write", ifid_write, 0);
    chk("lu bubble", idex_bubble, 1);
    tick(); idle();
    #1 chk("lu stall_cnt", stall_cnt, 1);
    chk("lu pc_write after", pc_write, 1);

    // Branch on ALU result: stall, then flush
    tick(); id_branch = 1; branch_taken = 1; idex_regwrite = 1; idex_dst = 9; ifid_rt = 9;
    #1 chk("bralu flush while stall", ifid_flush, 0);
    chk("bralu pc_write", pc_write, 0);
    tick(); idex_regwrite = 0; idex_dst = 0;
    #1 chk("bralu flush", ifid_flush, 1);
    chk("bralu stall_cnt", stall_cnt, 2);
    tick(); idle();
    #1 chk("bralu flush_cnt", flush_cnt, 1);

    // Branch on load: two stall cycles
    tick(); idex_memread = 1; idex_dst = 10; ifid_rs = 10; id_branch = 1;
    #1 chk("brld c1 pc_write", pc_write, 0);
    tick(); idex_memread = 0; idex_dst = 0; exmem_memread = 1; exmem_rd = 10;
    #1 chk("brld c2 bubble", idex_bubble, 1);
    tick(); idle();
    #1 chk("brld stall_cnt", stall_cnt, 4);
    chk("brld err", err, 0);

    // Register 0 never hazards
    tick(); idex_memread = 1; idex_dst = 0; ifid_rs = 0;
    #1 chk("r0 pc_write", pc_write, 1);
    chk("r0 bubble", idex_bubble, 0);

    // Watchdog: four consecutive stalls
    tick(); idle(); load_use_8();
    repeat (3) tick();
    #1 chk("wd err after 3", err, 0);
    tick(); idle();
    #1 chk("wd err after 4", err, 1);
    chk("wd stall_cnt", stall_cnt, 8);
    tick();
    #1 chk("wd err sticky", err, 1);

    // Reset mid-stall
    tick(); rst = 1;
    tick(); rst = 0; idle(); load_use_8();
    repeat (3) tick();
    #1 chk("mid stall_cnt", stall_cnt, 3);
    chk("mid pc_write", pc_write, 0);
    rst = 1;
    #1 chk("mid rst stall_cnt", stall_cnt, 0);
    chk("mid rst flush_cnt", flush_cnt, 0);
    chk("mid rst err", err, 0);
    chk("mid rst bubble", idex_bubble, 1);
    chk("mid rst pc_write", pc_write, 0);
    tick(); rst = 0; idle();
    #1 chk("mid release pc_write", pc_write, 1);
    chk("mid release stall_cnt", stall_cnt, 0);

    // Randomized traffic with small register numbers to force frequent matches
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (rst) rst = 0;
      if ($urandom_range(0, 3) != 0) begin
        ifid_rs       = 5'($urandom_range(0, 3));
        ifid_rt       = 5'($urandom_range(0, 3));
        idex_dst      = 5'($urandom_range(0, 3));
        exmem_rd      = 5'($urandom_range(0, 3));
        id_branch     = 1'($urandom_range(0, 1));
        branch_taken  = 1'($urandom_range(0, 1));
        jump          = ($urandom_range(0, 7) == 0);
        idex_regwrite = 1'($urandom_range(0, 1));
        idex_memread  = 1'($urandom_range(0, 1));
        exmem_memread = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1;
      end
    end

    tick();
    rst = 0;
    idle();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
